lane_burst_arbiter: RTL and testbench
=====================================

# lane_burst_arbiter

Round-robin write-side controller for the shared multi-lane ring buffer. Grants one of NUM_LANE DMA lane requesters exclusive access for a full burst of BURST_LENGTH words, only when the buffer has room for the whole burst. Tracks buffer occupancy from its own writes and the consumer's read strobes, and drives the buffer's write port directly.

## Interface
- DATA_WIDTH, 32, word width
- BURST_LENGTH, 128, words per granted burst
- NUM_LANE, 4, number of requesting lanes
- TIMEOUT_CYCLES, 256, stall limit per burst (used only with LBA_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_LANE  lane i has a full burst pending; level, held until granted
- lane_valid  in  NUM_LANE  lane i data word valid
- lane_data  in  NUM_LANE×DATA_WIDTH  per-lane data
- lane_ready  out  NUM_LANE  word accepted from lane i this cycle
- grant  out  NUM_LANE  one-hot owner during a burst, else 0
- buf_wen  out  1  buffer write strobe
- buf_din  out  DATA_WIDTH  buffer write data
- buf_ren  in  1  consumer read strobe (observed only)
- occupancy  out  clog2(NUM_LANE*BURST_LENGTH)+1  words currently stored
- burst_done  out  1  one-cycle pulse on last word of a burst
- busy  out  1  FSM not in IDLE
- err_underflow  out  1  sticky: buf_ren seen with occupancy 0
- timeout_abort  out  1  one-cycle pulse on burst abort (0 when macro absent)

## Operation
- DEPTH = NUM_LANE*BURST_LENGTH; free = DEPTH − occupancy.
- FSM states: IDLE, BURST.
- IDLE: if |req and free ≥ BURST_LENGTH, select the first requesting lane after last_grant (circular, ascending index); register grant, load beat counter to 0, go BURST. Otherwise stay.
- BURST: lane_ready[g] = 1 for granted lane g only; transfer = lane_valid[g] & lane_ready[g]. On transfer: buf_wen = 1, buf_din = lane_data[g], counter +1. When the transfer occurs at counter = BURST_LENGTH−1: burst_done = 1, last_grant ← g, grant ← 0, go IDLE.
- Non-granted lanes: lane_ready = 0; their lane_valid is ignored.
- buf_wen, buf_din, lane_ready are combinational from state, grant and lane_valid (zero-bubble streaming).
- Occupancy: +1 on buf_wen, −1 on buf_ren when occupancy > 0; both together: unchanged. buf_ren at occupancy 0: no change, set err_underflow.
- Free-space check at grant time guarantees no write into a full buffer during a burst.

## Timing
- Reset values: grant 0, lane_ready 0, buf_wen 0, buf_din 0, occupancy 0, burst_done 0, busy 0, err_underflow 0, timeout_abort 0; FSM IDLE; last_grant = NUM_LANE−1, so lane 0 wins first.
- Grant latency: req sampled in IDLE at edge N -> grant/busy high after edge N, first data transfer possible in cycle N+1.
- Minimum burst: BURST_LENGTH cycles; one IDLE cycle between consecutive bursts (re-arbitration).
- Occupancy updates on the edge following the strobe; it is sampled by the IDLE free check in the same cycle it is registered.
- Dropping req during BURST has no effect; the burst runs to completion.
- rst mid-burst: immediate return to reset values; partial burst is not rolled back (buffer pointers are reset by the same rst).

## Configuration
- LBA_TIMEOUT_EN defined: stall counter clears on every transfer, increments each BURST cycle without transfer; reaching TIMEOUT_CYCLES -> timeout_abort pulse, grant ← 0, last_grant ← g, go IDLE; written words stay counted in occupancy.
- LBA_TIMEOUT_EN undefined: no stall counter; bursts wait indefinitely; timeout_abort tied 0.

## Test plan
- Reset, req=4'b0001, lane 0 valid every cycle -> grant=0001 one cycle later, 128 consecutive buf_wen, burst_done on 128th word, occupancy=128.
- req=4'b1111 held, no reads -> grants in order lane 0,1,2,3; after 4 bursts occupancy=512, no further grant while req stays high.
- Buffer at occupancy 400, req=0010 -> no grant; pulse buf_ren 16 times -> occupancy 384, grant=0010 next cycle.
- During burst, simultaneous buf_wen and buf_ren each cycle -> occupancy constant; buf_ren at occupancy 0 -> occupancy stays 0, err_underflow=1 until reset.
- Lane 2 deasserts lane_valid for 10 cycles mid-burst -> buf_wen low those cycles, counter holds, burst completes with exactly 128 writes; assert rst at word 60 -> all outputs at reset values next cycle.
- With LBA_TIMEOUT_EN, TIMEOUT_CYCLES=256: lane stalls after 50 words -> timeout_abort after 256 idle cycles, occupancy=50, next requester granted after one IDLE cycle.

Source files
------------

// File: rtl/lane_burst_arbiter.sv
// lane_burst_arbiter: round-robin burst write controller for the shared ring buffer.
// Optional per-burst stall abort is enabled by defining LBA_TIMEOUT_EN.
module lane_burst_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int BURST_LENGTH   = 128,
   parameter int NUM_LANE       = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_LANE-1:0]                    req,
   input  logic [NUM_LANE-1:0]                    lane_valid,
   input  logic [NUM_LANE*DATA_WIDTH-1:0]         lane_data,
   output logic [NUM_LANE-1:0]                    lane_ready,
   output logic [NUM_LANE-1:0]                    grant,
   output logic                                   buf_wen,
   output logic [DATA_WIDTH-1:0]                  buf_din,
   input  logic                                   buf_ren,
   output logic [$clog2(NUM_LANE*BURST_LENGTH):0] occupancy,
   output logic                                   burst_done,
   output logic                                   busy,
   output logic                                   err_underflow,
   output logic                                   timeout_abort
);

   localparam int DEPTH = NUM_LANE * BURST_LENGTH;
   localparam int OCC_W = $clog2(DEPTH) + 1;
   localparam int CNT_W = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
   localparam int IDX_W = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t             state, state_n;
   logic [NUM_LANE-1:0] grant_n;
   logic [IDX_W-1:0]   gidx, gidx_n;
   logic [IDX_W-1:0]   last_grant, last_n;
   logic [IDX_W-1:0]   pick, cand;
   logic [CNT_W-1:0]   beat, beat_n;
   logic [OCC_W-1:0]   occ_n;
   logic               err_n;
   logic               room;
   logic               xfer;
   logic               last_beat;
   logic               stall_hit;

   assign room      = occupancy <= OCC_W'(DEPTH - BURST_LENGTH);
   assign xfer      = (state == BURST) && |(lane_valid & grant);
   assign last_beat = beat == CNT_W'(BURST_LENGTH - 1);

   assign lane_ready = grant;
   assign busy       = state == BURST;
   assign buf_wen    = xfer;
   assign buf_din    = xfer ?
      lane_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign burst_done = xfer && last_beat;

   // scan downwards so the lane closest after last_grant wins
   always_comb begin
      pick = last_grant;
      cand = '0;
      for (int k = NUM_LANE; k >= 1; k--) begin
         cand = IDX_W'((int'(last_grant) + k) % NUM_LANE);
         if (req[cand]) pick = cand;
      end
   end

`ifdef LBA_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [STALL_W-1:0] stall, stall_n;

   assign stall_hit = (state == BURST) && !xfer &&
      (stall == STALL_W'(TIMEOUT_CYCLES - 1));
   assign timeout_abort = stall_hit;

   always_comb begin
      stall_n = '0;
      if (state == BURST && !xfer) stall_n = stall + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall <= '0;
      else     stall <= stall_n;
   end
`else
   logic unused_cfg;

   assign unused_cfg    = |TIMEOUT_CYCLES;
   assign stall_hit     = 1'b0;
   assign timeout_abort = 1'b0;
`endif

   always_comb begin
      state_n = state;
      grant_n = grant;
      gidx_n  = gidx;
      last_n  = last_grant;
      beat_n  = beat;
      unique case (state)
         IDLE: begin
            if (|req && room) begin
               state_n = BURST;
               grant_n = NUM_LANE'(1) << pick;
               gidx_n  = pick;
               beat_n  = '0;
            end
         end
         BURST: begin
            if (xfer) beat_n = beat + 1'b1;
            if (burst_done || stall_hit) begin
               state_n = IDLE;
               grant_n = '0;
               last_n  = gidx;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // simultaneous write and read leave the count unchanged
   always_comb begin
      occ_n = occupancy;
      err_n = err_underflow;
      if (buf_ren && occupancy == '0) err_n = 1'b1;
      if (buf_wen && !buf_ren)
         occ_n = occupancy + 1'b1;
      else if (!buf_wen && buf_ren && occupancy != '0)
         occ_n = occupancy - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         grant         <= '0;
         gidx          <= '0;
         last_grant    <= IDX_W'(NUM_LANE - 1);
         beat          <= '0;
         occupancy     <= '0;
         err_underflow <= 1'b0;
      end else begin
         state         <= state_n;
         grant         <= grant_n;
         gidx          <= gidx_n;
         last_grant    <= last_n;
         beat          <= beat_n;
         occupancy     <= occ_n;
         err_underflow <= err_n;
      end
   end

endmodule

// File: tb/tb_lane_burst_arbiter.sv
// tb_lane_burst_arbiter: vector table, corner sequences and random traffic
// checked against a lane/occupancy model of the arbiter.
`timescale 1ns/1ps
module tb_lane_burst_arbiter;

   localparam int DW    = 32;
   localparam int BL    = 128;
   localparam int NL    = 4;
   localparam int TO    = 256;
   localparam int DEPTH = NL * BL;
   localparam int OW    = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NL-1:0]     req = '0;
   logic [NL-1:0]     lane_valid = '0;
   logic [NL*DW-1:0]  lane_data = '0;
   logic [NL-1:0]     lane_ready;
   logic [NL-1:0]     grant;
   logic              buf_wen;
   logic [DW-1:0]     buf_din;
   logic              buf_ren = 1'b0;
   logic [OW-1:0]     occupancy;
   logic              burst_done;
   logic              busy;
   logic              err_underflow;
   logic              timeout_abort;

   lane_burst_arbiter #(
      .DATA_WIDTH(DW), .BURST_LENGTH(BL),
      .NUM_LANE(NL), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .req(req),
      .lane_valid(lane_valid), .lane_data(lane_data),
      .lane_ready(lane_ready), .grant(grant),
      .buf_wen(buf_wen), .buf_din(buf_din),
      .buf_ren(buf_ren), .occupancy(occupancy),
      .burst_done(burst_done), .busy(busy),
      .err_underflow(err_underflow),
      .timeout_abort(timeout_abort)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int n_wen, n_done, n_abort;

   // model: owner lane (-1 when idle), words written, stall run, occupancy
   int m_own, m_cnt, m_last, m_occ, m_stall;
   bit m_err;

   task automatic check(input string nm, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   function automatic logic [63:0] dut_vec();
      return {grant, lane_ready, buf_wen, buf_din, burst_done,
              busy, occupancy, err_underflow, timeout_abort};
   endfunction

   function automatic bit m_xfer();
      return (m_own >= 0) ? lane_valid[m_own] : 1'b0;
   endfunction

   function automatic logic [63:0] model_vec();
      logic [NL-1:0] g;
      logic [DW-1:0] d;
      bit x, dn, ab;
      g  = (m_own >= 0) ? NL'(1) << m_own : '0;
      x  = m_xfer();
      d  = x ? lane_data[m_own*DW +: DW] : '0;
      dn = x && (m_cnt == BL - 1);
`ifdef LBA_TIMEOUT_EN
      ab = (m_own >= 0) && !x && (m_stall == TO - 1);
`else
      ab = 1'b0;
`endif
      return {g, g, x, d, dn, m_own >= 0, OW'(m_occ), m_err, ab};
   endfunction

   task automatic model_step();
      bit x;
      x = m_xfer();
      if (m_own < 0) begin
         if (req != 0 && DEPTH - m_occ >= BL) begin
            for (int k = 1; k <= NL; k++)
               if (req[(m_last + k) % NL]) begin
                  m_own = (m_last + k) % NL;
                  break;
               end
            m_cnt = 0;
            m_stall = 0;
         end
      end else if (x) begin
         m_cnt++;
         m_stall = 0;
         if (m_cnt == BL) begin
            m_last = m_own;
            m_own = -1;
         end
      end else begin
         m_stall++;
`ifdef LBA_TIMEOUT_EN
         if (m_stall == TO) begin
            m_last = m_own;
            m_own = -1;
         end
`endif
      end
      if (buf_ren && m_occ == 0) m_err = 1'b1;
      if (x && !buf_ren) m_occ++;
      else if (!x && buf_ren && m_occ > 0) m_occ--;
   endtask

   task automatic cycle(input logic [NL-1:0] r, input logic [NL-1:0] v,
                        input logic ren, input string nm);
      @(negedge clk);
      req = r;
      lane_valid = v;
      buf_ren = ren;
      for (int i = 0; i < NL; i++) lane_data[i*DW +: DW] = $urandom;
      #1;
      check(nm, dut_vec(), model_vec());
      if (buf_wen) n_wen++;
      if (burst_done) n_done++;
      if (timeout_abort) n_abort++;
      @(posedge clk);
      model_step();
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      lane_valid = '0;
      buf_ren = 1'b0;
      lane_data = '0;
      #1;
      check(nm, dut_vec(), 64'h0);
      m_own = -1; m_cnt = 0; m_last = NL - 1;
      m_occ = 0; m_stall = 0; m_err = 1'b0;
      n_wen = 0; n_done = 0; n_abort = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_state(input string nm, input logic [NL-1:0] g,
                              input int occ, input logic b, input logic e);
      #1;
      check(nm, {grant, occupancy, busy, err_underflow},
            {g, OW'(occ), b, e});
   endtask

   typedef struct {
      logic [NL-1:0] req;
      logic [NL-1:0] valid;
      logic          ren;
      int            n;
      logic [NL-1:0] g;
      int            occ;
      logic          busy;
      logic          err;
   } vec_t;

   vec_t tbl[$];

   initial begin
      tbl.push_back('{4'b0001, 4'hF, 1'b0,   1, 4'b0001,   0, 1'b1, 1'b0});
      tbl.push_back('{4'b0000, 4'hF, 1'b0, 127, 4'b0001, 127, 1'b1, 1'b0});
      tbl.push_back('{4'b0000, 4'hF, 1'b0,   1, 4'b0000, 128, 1'b0, 1'b0});
      tbl.push_back('{4'b1111, 4'hF, 1'b0,   1, 4'b0010, 128, 1'b1, 1'b0});
      tbl.push_back('{4'b1111, 4'hF, 1'b0, 128, 4'b0000, 256, 1'b0, 1'b0});
      tbl.push_back('{4'b1111, 4'hF, 1'b0,   1, 4'b0100, 256, 1'b1, 1'b0});
      tbl.push_back('{4'b1111, 4'hF, 1'b0, 128, 4'b0000, 384, 1'b0, 1'b0});
      tbl.push_back('{4'b1111, 4'hF, 1'b0,   1, 4'b1000, 384, 1'b1, 1'b0});
      tbl.push_back('{4'b1111, 4'hF, 1'b0, 128, 4'b0000, 512, 1'b0, 1'b0});
      tbl.push_back('{4'b1111, 4'hF, 1'b0,   4, 4'b0000, 512, 1'b0, 1'b0});
      tbl.push_back('{4'b0000, 4'h0, 1'b1, 112, 4'b0000, 400, 1'b0, 1'b0});
      tbl.push_back('{4'b0010, 4'h0, 1'b0,   5, 4'b0000, 400, 1'b0, 1'b0});
      tbl.push_back('{4'b0010, 4'h0, 1'b1,  16, 4'b0000, 384, 1'b0, 1'b0});
      tbl.push_back('{4'b0010, 4'hF, 1'b0,   1, 4'b0010, 384, 1'b1, 1'b0});
      tbl.push_back('{4'b0000, 4'hF, 1'b1, 128, 4'b0000, 384, 1'b0, 1'b0});
      tbl.push_back('{4'b0000, 4'h0, 1'b1, 384, 4'b0000,   0, 1'b0, 1'b0});
      tbl.push_back('{4'b0000, 4'h0, 1'b1,   3, 4'b0000,   0, 1'b0, 1'b1});

      do_reset("reset");
      foreach (tbl[i]) begin
         for (int c = 0; c < tbl[i].n; c++)
            cycle(tbl[i].req, tbl[i].valid, tbl[i].ren, "tbl_cyc");
         check_state($sformatf("tbl%0d", i), tbl[i].g, tbl[i].occ,
                     tbl[i].busy, tbl[i].err);
      end
      check("tbl_writes", n_wen, 640);
      check("tbl_bursts", n_done, 5);

      // lane 2 drops valid for 10 cycles mid-burst
      do_reset("reset_gap");
      cycle(4'b0100, 4'h0, 1'b0, "gap_cyc");
      check_state("gap_grant", 4'b0100, 0, 1'b1, 1'b0);
      for (int c = 0; c < 30; c++) cycle(4'b0000, 4'hF, 1'b0, "gap_cyc");
      for (int c = 0; c < 10; c++) cycle(4'b0000, 4'b1011, 1'b0, "gap_cyc");
      check_state("gap_hold", 4'b0100, 30, 1'b1, 1'b0);
      for (int c = 0; c < 98; c++) cycle(4'b0000, 4'hF, 1'b0, "gap_cyc");
      check_state("gap_end", 4'b0000, 128, 1'b0, 1'b0);
      check("gap_writes", n_wen, 128);
      check("gap_done", n_done, 1);

      // reset after 60 words of a burst
      cycle(4'b0100, 4'h0, 1'b0, "rst_cyc");
      for (int c = 0; c < 60; c++) cycle(4'b0000, 4'hF, 1'b0, "rst_cyc");
      check_state("rst_pre", 4'b0100, 188, 1'b1, 1'b0);
      do_reset("reset_mid");
      cycle(4'b0000, 4'hF, 1'b0, "rst_after");
      check_state("rst_post", 4'b0000, 0, 1'b0, 1'b0);

      // stall after 50 words
      do_reset("reset_stall");
      cycle(4'b0001, 4'h0, 1'b0, "stall_cyc");
      for (int c = 0; c < 50; c++) cycle(4'b0010, 4'hF, 1'b0, "stall_cyc");
      for (int c = 0; c < TO; c++) cycle(4'b0010, 4'h0, 1'b0, "stall_cyc");
`ifdef LBA_TIMEOUT_EN
      check_state("stall_abort", 4'b0000, 50, 1'b0, 1'b0);
      check("stall_pulses", n_abort, 1);
      cycle(4'b0010, 4'h0, 1'b0, "stall_cyc");
      check_state("stall_next", 4'b0010, 50, 1'b1, 1'b0);
`else
      check_state("stall_wait", 4'b0001, 50, 1'b1, 1'b0);
      check("stall_pulses", n_abort, 0);
      cycle(4'b0010, 4'h1, 1'b0, "stall_cyc");
      check_state("stall_resume", 4'b0001, 51, 1'b1, 1'b0);
`endif

      do_reset("reset_rand");
      for (int c = 0; c < 4000; c++)
         cycle(NL'($urandom), NL'($urandom | $urandom),
               $urandom_range(0, 99) < 45, "rand_cyc");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
